// File: rtl/controle_multiciclo.sv
// controle_multiciclo: Moore sequencer for the 16-bit multi-cycle datapath.
// Outputs are registered from the next-state decode, so each output matches the state it is in.
module controle_multiciclo #(
   parameter int unsigned MEM_LAT = 1,
   parameter logic [3:0]  OP_ADD  = 4'h0,
   parameter logic [3:0]  OP_SUB  = 4'h1
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic [3:0]  opcode,
   input  logic        zero,
   input  logic        resume,
   output logic        EscIR,
   output logic        EscCP,
   output logic        EscCondCP,
   output logic [1:0]  FonteCP,
   output logic        ULA_A,
   output logic [1:0]  ULA_B,
   output logic [3:0]  ULA_OP,
   output logic        EscReg,
   output logic        flag_imm,
   output logic        halted,
   output logic        illegal,
   output logic [15:0] instr_count
);

   localparam int unsigned CW = 3;
   localparam logic [CW-1:0] CNT_RELOAD = CW'(MEM_LAT - 1);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      FWAIT  = 4'd1,
      DECODE = 4'd2,
      EXEC_R = 4'd3,
      EXEC_I = 4'd4,
      WB_R   = 4'd5,
      WB_I   = 4'd6,
      BRANCH = 4'd7,
      JUMP   = 4'd8,
      HALT   = 4'd9
   } state_t;

   state_t        state, stateNext;
   logic [CW-1:0] cnt, cntNext;
   logic [3:0]    opcodeQ, opcodeNext;

   logic       escIRNext, escCPNext, escCondCPNext, ulaANext;
   logic       escRegNext, flagImmNext, haltedNext, illegalNext;
   logic [1:0] fonteCPNext, ulaBNext;
   logic [3:0] ulaOpNext;

   // zero only qualifies the PC write inside the datapath; the sequence itself ignores it
   logic unusedZero;
   assign unusedZero = zero;

   // Next state, fetch wait counter and latched opcode
   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      opcodeNext = opcodeQ;
      case (state)
         FETCH:  stateNext = FWAIT;
         FWAIT: begin
            if (cnt == '0) begin
               opcodeNext = opcode;
               cntNext    = CNT_RELOAD;
               stateNext  = DECODE;
            end else begin
               cntNext = cnt - CW'(1);
            end
         end
         DECODE: begin
            if (opcodeQ <= 4'h5)      stateNext = EXEC_R;
            else if (opcodeQ <= 4'hA) stateNext = EXEC_I;
            else if (opcodeQ == 4'hB) stateNext = BRANCH;
            else if (opcodeQ == 4'hC) stateNext = JUMP;
            else if (opcodeQ == 4'hF) stateNext = HALT;
            else                      stateNext = FETCH;
         end
         EXEC_R: stateNext = WB_R;
         EXEC_I: stateNext = WB_I;
         WB_R, WB_I, BRANCH, JUMP: stateNext = FETCH;
         HALT:   if (resume) stateNext = FETCH;
         default: begin
            stateNext = FETCH;
            cntNext   = CNT_RELOAD;
         end
      endcase
   end

   // Moore output decode of the state being entered
   always_comb begin
      escIRNext     = 1'b0;
      escCPNext     = 1'b0;
      escCondCPNext = 1'b0;
      fonteCPNext   = 2'b00;
      ulaANext      = 1'b0;
      ulaBNext      = 2'b00;
      ulaOpNext     = 4'h0;
      escRegNext    = 1'b0;
      flagImmNext   = 1'b0;
      haltedNext    = 1'b0;
      illegalNext   = 1'b0;
      case (stateNext)
         FWAIT: begin
            if (cntNext == '0) begin
               escIRNext = 1'b1;
               escCPNext = 1'b1;
               ulaBNext  = 2'b01;
               ulaOpNext = OP_ADD;
            end
         end
         DECODE: begin
            ulaBNext    = 2'b10;
            ulaOpNext   = OP_ADD;
            illegalNext = (opcodeNext == 4'hD) || (opcodeNext == 4'hE);
         end
         EXEC_R: begin
            ulaANext  = 1'b1;
            ulaOpNext = opcodeNext;
         end
         EXEC_I: begin
            ulaANext    = 1'b1;
            ulaBNext    = 2'b10;
            ulaOpNext   = opcodeNext;
            flagImmNext = 1'b1;
         end
         WB_R: escRegNext = 1'b1;
         WB_I: begin
            escRegNext  = 1'b1;
            flagImmNext = 1'b1;
         end
         BRANCH: begin
            ulaANext      = 1'b1;
            ulaOpNext     = OP_SUB;
            escCondCPNext = 1'b1;
            fonteCPNext   = 2'b01;
         end
         JUMP: begin
            escCPNext   = 1'b1;
            fonteCPNext = 2'b10;
         end
         HALT:    haltedNext = 1'b1;
         default: ;
      endcase
   end

   // State, counter, opcode latch, instruction counter and registered outputs
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state       <= FETCH;
         cnt         <= CNT_RELOAD;
         opcodeQ     <= 4'h0;
         instr_count <= 16'h0000;
         EscIR       <= 1'b0;
         EscCP       <= 1'b0;
         EscCondCP   <= 1'b0;
         FonteCP     <= 2'b00;
         ULA_A       <= 1'b0;
         ULA_B       <= 2'b00;
         ULA_OP      <= 4'h0;
         EscReg      <= 1'b0;
         flag_imm    <= 1'b0;
         halted      <= 1'b0;
         illegal     <= 1'b0;
      end else begin
         state   <= stateNext;
         cnt     <= cntNext;
         opcodeQ <= opcodeNext;
         if (state == DECODE) instr_count <= instr_count + 16'd1;
         EscIR     <= escIRNext;
         EscCP     <= escCPNext;
         EscCondCP <= escCondCPNext;
         FonteCP   <= fonteCPNext;
         ULA_A     <= ulaANext;
         ULA_B     <= ulaBNext;
         ULA_OP    <= ulaOpNext;
         EscReg    <= escRegNext;
         flag_imm  <= flagImmNext;
         halted    <= haltedNext;
         illegal   <= illegalNext;
      end
   end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: stimulus pushes per-cycle expectations, a monitor pops them.
`timescale 1ns/1ps
module tb_controle_multiciclo;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;

   logic        CLOCK_50 = 1'b0;
   logic        reset;
   logic [3:0]  opcode;
   logic        zero;
   logic        resume;

   logic        EscIR, EscCP, EscCondCP, ULA_A, EscReg, flag_imm, halted, illegal;
   logic [1:0]  FonteCP, ULA_B;
   logic [3:0]  ULA_OP;
   logic [15:0] instr_count;

   logic        EscIR3, EscCP3, EscCondCP3, ULA_A3, EscReg3, flag_imm3, halted3, illegal3;
   logic [1:0]  FonteCP3, ULA_B3;
   logic [3:0]  ULA_OP3;
   logic [15:0] instr_count3;

   int errors = 0;
   int checks = 0;

   logic [31:0] expQ[$];
   string       tagQ[$];
   logic [15:0] expCnt;

   always #10 CLOCK_50 = ~CLOCK_50;

   controle_multiciclo #(.MEM_LAT(1), .OP_ADD(OP_ADD), .OP_SUB(OP_SUB)) u_dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .opcode(opcode), .zero(zero), .resume(resume),
      .EscIR(EscIR), .EscCP(EscCP), .EscCondCP(EscCondCP), .FonteCP(FonteCP),
      .ULA_A(ULA_A), .ULA_B(ULA_B), .ULA_OP(ULA_OP), .EscReg(EscReg),
      .flag_imm(flag_imm), .halted(halted), .illegal(illegal), .instr_count(instr_count)
   );

   controle_multiciclo #(.MEM_LAT(3), .OP_ADD(OP_ADD), .OP_SUB(OP_SUB)) u_dut3 (
      .CLOCK_50(CLOCK_50), .reset(reset), .opcode(opcode), .zero(zero), .resume(resume),
      .EscIR(EscIR3), .EscCP(EscCP3), .EscCondCP(EscCondCP3), .FonteCP(FonteCP3),
      .ULA_A(ULA_A3), .ULA_B(ULA_B3), .ULA_OP(ULA_OP3), .EscReg(EscReg3),
      .flag_imm(flag_imm3), .halted(halted3), .illegal(illegal3), .instr_count(instr_count3)
   );

   // Packed view of the outputs: {EscIR,EscCP,EscCondCP,FonteCP,ULA_A,ULA_B,ULA_OP,EscReg,flag_imm,halted,illegal}
   function automatic logic [15:0] v(input logic ir, input logic cp, input logic ccp,
                                     input logic [1:0] fc, input logic ua, input logic [1:0] ub,
                                     input logic [3:0] op, input logic er, input logic fi,
                                     input logic h, input logic il);
      return {ir, cp, ccp, fc, ua, ub, op, er, fi, h, il};
   endfunction

   function automatic logic [15:0] dutVec();
      return {EscIR, EscCP, EscCondCP, FonteCP, ULA_A, ULA_B, ULA_OP, EscReg, flag_imm, halted, illegal};
   endfunction

   function automatic logic [15:0] dut3Vec();
      return {EscIR3, EscCP3, EscCondCP3, FonteCP3, ULA_A3, ULA_B3, ULA_OP3, EscReg3, flag_imm3, halted3, illegal3};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Push the expectation for the current cycle, then advance to the next cycle start
   task automatic cyc(input logic [15:0] ev, input string tag);
      expQ.push_back({ev, expCnt});
      tagQ.push_back(tag);
      @(posedge CLOCK_50);
      #1;
   endtask

   // One full instruction on the MEM_LAT=1 instance
   task automatic instr(input logic [3:0] op, input logic z, input logic resumeInExec, input logic abortWb);
      string t;
      t = $sformatf("op%h", op);
      opcode = op;
      zero   = z;
      cyc(16'h0000, {t, "_fetch"});
      cyc(v(1,1,0,2'b00,0,2'b01,OP_ADD,0,0,0,0), {t, "_fwait"});
      cyc(v(0,0,0,2'b00,0,2'b10,OP_ADD,0,0,0,(op == 4'hD) || (op == 4'hE)), {t, "_decode"});
      expCnt = expCnt + 16'd1;
      if (op <= 4'h5) begin
         resume = resumeInExec;
         cyc(v(0,0,0,2'b00,1,2'b00,op,0,0,0,0), {t, "_exec_r"});
         resume = 1'b0;
         if (abortWb) begin
            chk({t, "_wb_escreg"}, 32'(EscReg), 32'd1);
            reset = 1'b1;
            #1;
            chk("abort_escreg", 32'(EscReg), 32'd0);
            chk("abort_count", 32'(instr_count), 32'd0);
            chk("abort_outs", 32'(dutVec()), 32'd0);
            expCnt = 16'h0000;
         end else begin
            cyc(v(0,0,0,2'b00,0,2'b00,4'h0,1,0,0,0), {t, "_wb_r"});
         end
      end else if (op <= 4'hA) begin
         cyc(v(0,0,0,2'b00,1,2'b10,op,0,1,0,0), {t, "_exec_i"});
         cyc(v(0,0,0,2'b00,0,2'b00,4'h0,1,1,0,0), {t, "_wb_i"});
      end else if (op == 4'hB) begin
         cyc(v(0,0,1,2'b01,1,2'b00,OP_SUB,0,0,0,0), {t, "_branch"});
      end else if (op == 4'hC) begin
         cyc(v(0,1,0,2'b10,0,2'b00,4'h0,0,0,0,0), {t, "_jump"});
      end else if (op == 4'hF) begin
         cyc(v(0,0,0,2'b00,0,2'b00,4'h0,0,0,1,0), {t, "_halt"});
      end
   endtask

   // Monitor: compare outputs against the queued expectation in mid-cycle
   initial begin
      forever begin
         @(negedge CLOCK_50);
         if (expQ.size() > 0) begin
            logic [31:0] e;
            string       tg;
            e  = expQ.pop_front();
            tg = tagQ.pop_front();
            chk({tg, "_outs"}, 32'(dutVec()), 32'(e[31:16]));
            chk({tg, "_count"}, 32'(instr_count), 32'(e[15:0]));
         end
      end
   end

   // MEM_LAT=3 instance: EscIR only in the third FWAIT cycle after the first reset release
   initial begin
      @(negedge reset);
      for (int k = 1; k <= 4; k++) begin
         @(negedge CLOCK_50);
         chk($sformatf("lat3_escir_c%0d", k), 32'(EscIR3), (k == 4) ? 32'd1 : 32'd0);
      end
      chk("lat3_fwait_outs", 32'(dut3Vec()), 32'(v(1,1,0,2'b00,0,2'b01,OP_ADD,0,0,0,0)));
   end

   // Watchdog
   initial begin
      #20_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset  = 1'b1;
      opcode = 4'h0;
      zero   = 1'b0;
      resume = 1'b0;
      expCnt = 16'h0000;
      #15;
      chk("reset_outs", 32'(dutVec()), 32'd0);
      chk("reset_count", 32'(instr_count), 32'd0);
      chk("reset_outs3", 32'(dut3Vec()), 32'd0);
      @(posedge CLOCK_50);
      #1;
      reset = 1'b0;

      instr(4'h0, 1'b0, 1'b0, 1'b0);
      instr(4'h7, 1'b0, 1'b0, 1'b0);
      instr(4'hB, 1'b1, 1'b0, 1'b0);
      instr(4'hB, 1'b0, 1'b0, 1'b0);
      instr(4'hC, 1'b0, 1'b0, 1'b0);
      instr(4'hD, 1'b0, 1'b0, 1'b0);
      instr(4'h2, 1'b0, 1'b1, 1'b0);
      instr(4'hA, 1'b0, 1'b0, 1'b0);
      instr(4'hF, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 19; i++) cyc(v(0,0,0,2'b00,0,2'b00,4'h0,0,0,1,0), "halt_hold");
      resume = 1'b1;
      cyc(v(0,0,0,2'b00,0,2'b00,4'h0,0,0,1,0), "halt_resume");
      resume = 1'b0;
      instr(4'h5, 1'b0, 1'b0, 1'b0);
      instr(4'h3, 1'b0, 1'b0, 1'b1);

      // Reset is held from the abort point; release it at the start of a cycle
      @(posedge CLOCK_50);
      #1;
      chk("held_reset_count", 32'(instr_count), 32'd0);
      reset = 1'b0;

      // 65535 illegal-opcode nops, three cycles each, to bring the counter to 0xFFFF
      opcode = 4'hD;
      repeat (3 * 65535) @(posedge CLOCK_50);
      #1;
      chk("preload_count", 32'(instr_count), 32'h0000_FFFF);
      expCnt = 16'hFFFF;
      instr(4'h0, 1'b0, 1'b0, 1'b0);
      instr(4'hC, 1'b0, 1'b0, 1'b0);

      @(negedge CLOCK_50);
      #1;
      chk("queue_drained", 32'(expQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
